// File: rtl/prog_sequencer.sv
// Program launch sequencer: edge-detects prioritised button requests, holds program_selector for a launch window, then waits for done or timeout.
// Build option: define PROG_SEQ_QUEUE_EN to add a one-deep pending-launch slot.
module prog_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_fib,
  input  logic        req_sort,
  input  logic        req_save,
  input  logic        req_load,
  input  logic        done,
  output logic [31:0] program_selector,
  output logic        busy,
  output logic [2:0]  last_prog,
  output logic        timeout_err,
  output logic [7:0]  drop_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2
  } state_t;

  localparam logic [7:0]  HOLD_LAST    = 8'(HOLD_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  armed;
  logic [7:0]  hold_cnt;
  logic [15:0] run_cnt;
  logic [2:0]  cur_prog;

  logic [3:0]  req_vec;
  logic [3:0]  fire_vec;
  logic        fire;
  logic [2:0]  fire_code;
  logic        busy_now;
  logic        timed_out;
  logic        exiting;
  logic        drop_fire;
  logic        relaunch;
  logic [2:0]  relaunch_code;

`ifdef PROG_SEQ_QUEUE_EN
  logic        pend_valid;
  logic [2:0]  pend_prog;
  logic        store_pend;
`endif

  // armed holds the inverse of last cycle's request level; reset clears it so a
  // request still held across reset must drop and rise again before it fires.
  always_comb begin
    req_vec  = {req_load, req_save, req_sort, req_fib};
    fire_vec = req_vec & armed;
    fire     = |fire_vec;
    if (fire_vec[0])      fire_code = 3'd1;
    else if (fire_vec[1]) fire_code = 3'd2;
    else if (fire_vec[2]) fire_code = 3'd3;
    else if (fire_vec[3]) fire_code = 3'd4;
    else                  fire_code = 3'd0;
    busy_now  = (state != IDLE);
    timed_out = (run_cnt == TIMEOUT_LAST);
    exiting   = (state == RUN) && (done || timed_out);
  end

  always_comb begin
    drop_fire     = 1'b0;
    relaunch      = 1'b0;
    relaunch_code = '0;
`ifdef PROG_SEQ_QUEUE_EN
    store_pend = 1'b0;
    if (pend_valid) begin
      relaunch      = 1'b1;
      relaunch_code = pend_prog;
    end
    // A busy fire landing on the exit edge with an empty slot launches straight away.
    if (fire && busy_now) begin
      if (pend_valid) begin
        drop_fire = 1'b1;
      end else if (exiting) begin
        relaunch      = 1'b1;
        relaunch_code = fire_code;
      end else begin
        store_pend = 1'b1;
      end
    end
`else
    drop_fire = fire && busy_now;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      armed            <= '0;
      hold_cnt         <= '0;
      run_cnt          <= '0;
      cur_prog         <= '0;
      program_selector <= '0;
      busy             <= 1'b0;
      last_prog        <= '0;
      timeout_err      <= 1'b0;
      drop_count       <= '0;
    end else begin
      armed <= ~req_vec;
      if (drop_fire && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (fire) begin
            state            <= LAUNCH;
            cur_prog         <= fire_code;
            program_selector <= {29'd0, fire_code};
            hold_cnt         <= '0;
            busy             <= 1'b1;
          end
        end

        LAUNCH: begin
          if (hold_cnt == HOLD_LAST) begin
            state            <= RUN;
            program_selector <= '0;
            run_cnt          <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        RUN: begin
          if (exiting) begin
            last_prog <= cur_prog;
            if (!done)
              timeout_err <= 1'b1;
            hold_cnt <= '0;
            busy     <= relaunch;
            if (relaunch) begin
              state            <= LAUNCH;
              cur_prog         <= relaunch_code;
              program_selector <= {29'd0, relaunch_code};
            end else begin
              state            <= IDLE;
              program_selector <= '0;
            end
          end else begin
            run_cnt <= run_cnt + 16'd1;
          end
        end

        default: begin
          state            <= IDLE;
          program_selector <= '0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_SEQ_QUEUE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_prog  <= '0;
    end else if (exiting) begin
      pend_valid <= 1'b0;
    end else if (store_pend) begin
      pend_valid <= 1'b1;
      pend_prog  <= fire_code;
    end
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer (HOLD_CYCLES=4, TIMEOUT=6); expectations adapt to PROG_SEQ_QUEUE_EN.
module tb_prog_sequencer;

  logic        clock;
  logic        reset;
  logic        req_fib, req_sort, req_save, req_load;
  logic        done;
  logic [31:0] program_selector;
  logic        busy;
  logic [2:0]  last_prog;
  logic        timeout_err;
  logic [7:0]  drop_count;

`ifdef PROG_SEQ_QUEUE_EN
  localparam int Q = 1;
`else
  localparam int Q = 0;
`endif
  localparam logic [7:0] D2 = (Q != 0) ? 8'd1 : 8'd2;
  localparam logic [2:0] LB = (Q != 0) ? 3'd3 : 3'd1;

  typedef struct {
    logic        rst;
    logic [3:0]  req;   // {load, save, sort, fib}
    logic        done;
    logic [31:0] sel;
    logic        busy;
    logic [2:0]  last;
    logic        terr;
    logic [7:0]  drop;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  prog_sequencer #(.HOLD_CYCLES(4), .TIMEOUT(6)) dut (
    .clock(clock), .reset(reset),
    .req_fib(req_fib), .req_sort(req_sort), .req_save(req_save), .req_load(req_load),
    .done(done),
    .program_selector(program_selector), .busy(busy), .last_prog(last_prog),
    .timeout_err(timeout_err), .drop_count(drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic rst, input logic [3:0] req, input logic dn,
                              input logic [31:0] sel, input logic bsy, input logic [2:0] last,
                              input logic terr, input logic [7:0] drop);
    vec_t v;
    v.rst = rst; v.req = req; v.done = dn; v.sel = sel;
    v.busy = bsy; v.last = last; v.terr = terr; v.drop = drop;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic rst, input logic [3:0] req, input logic dn);
    @(negedge clock);
    reset = rst;
    {req_load, req_save, req_sort, req_fib} = req;
    done = dn;
    @(posedge clock);
    #1;
  endtask

  task automatic step(input string tag, input vec_t v);
    vec_t e;
    @(negedge clock);
    reset = v.rst;
    {req_load, req_save, req_sort, req_fib} = v.req;
    done = v.done;
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({tag, " sel"},  program_selector, e.sel);
    chk({tag, " busy"}, {31'd0, busy}, {31'd0, e.busy});
    chk({tag, " last"}, {29'd0, last_prog}, {29'd0, e.last});
    chk({tag, " terr"}, {31'd0, timeout_err}, {31'd0, e.terr});
    chk({tag, " drop"}, {24'd0, drop_count}, {24'd0, e.drop});
  endtask

  task automatic stp(input string tag, input logic rst, input logic [3:0] req, input logic dn,
                     input logic [31:0] sel, input logic bsy, input logic [2:0] last,
                     input logic terr, input logic [7:0] drop);
    vec_t v;
    v.rst = rst; v.req = req; v.done = dn; v.sel = sel;
    v.busy = bsy; v.last = last; v.terr = terr; v.drop = drop;
    step(tag, v);
  endtask

  initial begin
    reset = 1'b1;
    {req_load, req_save, req_sort, req_fib} = 4'b0000;
    done = 1'b0;

    // reset state, then one quiet cycle to arm the edge detectors
    add(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(1, 4'b0000, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0);
    // fib launch: selector=1 for exactly 4 cycles, done ignored in LAUNCH
    add(0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 1, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 1, 0, 0, 0);
    add(0, 4'b0000, 1, 0, 0, 1, 0, 0);
    // sort+load together: sort wins; held load never re-fires
    add(0, 4'b1010, 0, 2, 1, 1, 0, 0);
    add(0, 4'b1000, 0, 2, 1, 1, 0, 0);
    add(0, 4'b1000, 0, 2, 1, 1, 0, 0);
    add(0, 4'b1000, 0, 2, 1, 1, 0, 0);
    add(0, 4'b1000, 0, 0, 1, 1, 0, 0);
    add(0, 4'b1000, 1, 0, 0, 2, 0, 0);
    add(0, 4'b1000, 0, 0, 0, 2, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 2, 0, 0);
    // fib run with two save fires while busy
    add(0, 4'b0001, 0, 1, 1, 2, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 2, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 2, 0, 0);
    add(0, 4'b0000, 0, 1, 1, 2, 0, 0);
    add(0, 4'b0000, 0, 0, 1, 2, 0, 0);
    add(0, 4'b0100, 0, 0, 1, 2, 0, (Q != 0) ? 8'd0 : 8'd1);
    add(0, 4'b0000, 0, 0, 1, 2, 0, (Q != 0) ? 8'd0 : 8'd1);
    add(0, 4'b0100, 0, 0, 1, 2, 0, D2);
    add(0, 4'b0000, 1, (Q != 0) ? 32'd3 : 32'd0, Q[0], 1, 0, D2);
    add(0, 4'b0000, 0, (Q != 0) ? 32'd3 : 32'd0, Q[0], 1, 0, D2);
    add(0, 4'b0000, 1, (Q != 0) ? 32'd3 : 32'd0, Q[0], 1, 0, D2);
    add(0, 4'b0000, 0, (Q != 0) ? 32'd3 : 32'd0, Q[0], 1, 0, D2);
    add(0, 4'b0000, 0, 0, Q[0], 1, 0, D2);
    add(0, 4'b0000, 1, 0, 0, LB, 0, D2);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("v%0d", i), vecs[i]);

    // save launch with no done: busy for HOLD+TIMEOUT cycles, then timeout
    for (int i = 0; i <= 10; i++)
      stp($sformatf("to%0d", i), 0, (i == 0) ? 4'b0100 : 4'b0000, 0,
          (i < 4) ? 32'd3 : 32'd0, (i < 10), (i == 10) ? 3'd3 : LB, (i == 10), D2);

    // fib after timeout launches normally; timeout_err stays sticky
    stp("fib_a", 0, 4'b0001, 0, 1, 1, 3, 1, D2);
    for (int i = 0; i < 3; i++)
      stp($sformatf("fib_h%0d", i), 0, 4'b0000, 0, 1, 1, 3, 1, D2);
    stp("fib_r", 0, 4'b0000, 0, 0, 1, 3, 1, D2);
    stp("fib_d", 0, 4'b0000, 1, 0, 0, 1, 1, D2);

    // reset during LAUNCH of load; held load must not launch afterwards
    stp("ld_a", 0, 4'b1000, 0, 4, 1, 1, 1, D2);
    stp("ld_b", 0, 4'b1000, 0, 4, 1, 1, 1, D2);
    stp("ld_rst", 1, 4'b1000, 0, 0, 0, 0, 0, 0);
    stp("ld_h0", 0, 4'b1000, 0, 0, 0, 0, 0, 0);
    stp("ld_h1", 0, 4'b1000, 0, 0, 0, 0, 0, 0);
    stp("ld_lo", 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    stp("ld_re", 0, 4'b1000, 0, 4, 1, 0, 0, 0);

    // done on the timeout cycle: done wins, no timeout_err
    for (int i = 1; i <= 10; i++)
      stp($sformatf("dt%0d", i), 0, 4'b0000, (i == 10),
          (i < 4) ? 32'd4 : 32'd0, (i < 10), (i == 10) ? 3'd4 : 3'd0, 0, 0);

    // continuous save toggling: drop_count must saturate and stay at 255
    for (int k = 0; k < 700; k++)
      drive(0, (k % 2 == 1) ? 4'b0100 : 4'b0000, 0);
    chk("drop_sat_a", {24'd0, drop_count}, 32'd255);
    for (int k = 0; k < 40; k++)
      drive(0, (k % 2 == 1) ? 4'b0100 : 4'b0000, 0);
    chk("drop_sat_b", {24'd0, drop_count}, 32'd255);

    drive(1, 4'b0000, 0);
    chk("final_rst_drop", {24'd0, drop_count}, 32'd0);
    chk("final_rst_sel", program_selector, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
